pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- PC register and instruction-fetch front end, directly downstream of the next-PC logic.
- Holds the fetch PC and issues in-order requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions with their PCs in a small queue and presents them to decode over valid/ready.
- Redirects from the next-PC logic (branch/jump targets) flush the queue and discard in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction queue entries; also the maximum of in-flight requests plus queued entries (power of 2, ≥2).

Ports:
- cpu_clk  in  1  clock; all state updates on rising edge.
- cpu_rst  in  1  reset; synchronous, active-high.
- redirect_valid  in  1  one-cycle pulse: next fetch comes from redirect_pc.
- redirect_pc  in  32  redirect target (npc on taken branch/jump).
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= fetch_pc).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst_out  out  32  head instruction.
- inst_pc  out  32  head PC.
- inst_pc4  out  32  inst_pc + 4, modulo 2^32.

Behaviour:
- Reset, checked in the cycle cpu_rst is high and the following cycle:
  - imem_req=0, inst_valid=0, inst_out=0, inst_pc=0, inst_pc4=4.
  - fetch_pc=resp_pc=RESET_PC.
  - outstanding=0, discard=0, queue empty, state=BOOT.
  - Reset mid-operation drops all in-flight work. Any rvalid while outstanding==0 is ignored.
- States:
  - BOOT: no requests; always goes to RUN next cycle.
  - RUN: normal fetch.
  - FLUSH: no requests; waits until discard==0, then goes to RUN.
- Request rule:
  - imem_req=1 iff state==RUN, !redirect_valid, and (outstanding + queue_count) < FIFO_DEPTH. Counting credits this way guarantees every response has a queue slot.
  - imem_addr=fetch_pc, held stable while imem_req && !imem_gnt.
  - On imem_req && imem_gnt: fetch_pc += 4 (wraps 32'hFFFF_FFFC→0) and outstanding++.
- Response rule, on imem_rvalid with outstanding>0:
  - outstanding--.
  - If discard>0: discard-- and drop the data.
  - Otherwise push {resp_pc, imem_rdata} and resp_pc += 4.
  - Simultaneous grant and response: outstanding unchanged.
- Output:
  - inst_valid = queue non-empty; inst_out/inst_pc = head.
  - Pop on inst_valid && inst_ready.
  - No bypass. A grant at cycle t with rvalid at t+k gives inst_valid earliest at t+k+1.
  - Push and pop in the same cycle are both allowed.
- Redirect (highest priority), in the redirect_valid cycle:
  - inst_valid forced 0 and imem_req forced 0.
  - Queue cleared.
  - fetch_pc = resp_pc = redirect_pc.
  - discard = outstanding minus 1 if a response arrives that same cycle (that response is itself dropped).
  - Next state = FLUSH if the new discard > 0, else RUN.
  - A redirect during BOOT or FLUSH is handled identically.
  - Back-to-back redirects: the last one wins.
- Full queue: no request is issued (by the credit rule); data is never lost.

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined:
  - Adds output port fetch_adef (1 bit, reset 0).
  - On a redirect with redirect_pc[1:0] != 0: fetch_adef=1 and state HALT. HALT issues no requests and has inst_valid=0.
  - Only a later aligned redirect or cpu_rst clears it.
- FETCH_ALIGN_CHECK_EN not defined:
  - No fetch_adef port.
  - redirect_pc[1:0] is treated as 0; the address is forced aligned.

Decomposition:
- Shared package/defines: FETCH_ST_BOOT/RUN/FLUSH/HALT state encodings, RESET_PC default, INST_NOP constant.
- One sub-module, fetch_queue: a synchronous FIFO (DEPTH parameter, 64-bit entry {pc, inst}) with push, pop, flush, count, empty and full.

Test Plan:
- Reset then sequential fetch, imem_gnt=1, 1-cycle response latency, inst_ready=1:
  - imem_addr is 0,4,8,… in consecutive cycles.
  - inst_pc=0 appears 2 cycles after the first grant; inst_pc4=4.
- Backpressure, inst_ready=0:
  - At most FIFO_DEPTH=2 grants, then imem_req=0.
  - One pop re-enables exactly one request.
- Redirect to 32'h0000_0100 with 2 requests outstanding:
  - Both responses are dropped; state is FLUSH for 2 response cycles.
  - The next imem_addr is 0x100; the first inst_pc is 0x100.
- Redirect in the same cycle as imem_rvalid with outstanding=1:
  - discard=0, FLUSH is skipped, and a request to the new target is issued next cycle.
- Wrap: redirect to 32'hFFFF_FFFC:
  - The following imem_addr is 0; inst_pc4 for that entry is 0.
- FETCH_ALIGN_CHECK_EN, redirect to 0x102:
  - fetch_adef=1 and no requests.
  - A redirect to 0x200 clears it and fetching resumes at 0x200.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_t  : front-end control states (BOOT, RUN, FLUSH, HALT)
//   fetch_entry_t  : one queued fetch result, {pc, inst}
//   RESET_PC_DEFAULT, INST_NOP, PC_STEP, PC_ALIGN_MASK : common constants
// Optional feature macro used by the fetch unit: FETCH_ALIGN_CHECK_EN
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_ST_BOOT  = 2'd0,
        FETCH_ST_RUN   = 2'd1,
        FETCH_ST_FLUSH = 2'd2,
        FETCH_ST_HALT  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_fetch_unit_fetch_queue.sv
// fetch_queue
// Synchronous FIFO holding fetched {pc, inst} pairs between the memory
// response path and decode.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : enqueue one entry
//   pop             : dequeue the head entry
//   flush           : drop every entry (takes priority over push/pop)
//   head            : current head entry (meaningful only when !empty)
//   count           : number of valid entries
//   empty, full     : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
    import pc_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full queue may still accept
    // a push when it is also being popped.
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush simply rewinds everything.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage has no reset: an entry is only observed after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// PC register and instruction-fetch front end. Issues in-order requests to
// instruction memory (req/gnt/rvalid), queues returned words with their PCs
// and hands them to decode over valid/ready. Redirects flush the queue and
// discard every response still in flight.
// Ports:
//   cpu_clk, cpu_rst            : clock, synchronous active-high reset
//   redirect_valid, redirect_pc : one-cycle redirect to a new fetch target
//   imem_req, imem_addr         : fetch request and address
//   imem_gnt                    : request accepted this cycle
//   imem_rvalid, imem_rdata     : in-order response
//   inst_valid, inst_ready      : decode handshake on the queue head
//   inst_out, inst_pc, inst_pc4 : head instruction, its PC and PC+4
//   fetch_adef                  : misaligned-redirect flag (only with
//                                 FETCH_ALIGN_CHECK_EN defined)
// Macro FETCH_ALIGN_CHECK_EN: when defined, a misaligned redirect halts fetch
// and raises fetch_adef; when undefined, redirect_pc[1:0] is ignored.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_adef
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t     state;
    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] outstanding_after_resp;
    logic [CNT_W:0]   credits_used;

    logic [CNT_W-1:0] q_count;
    logic             q_empty;
    logic             q_full;
    fetch_entry_t     q_head;
    fetch_entry_t     q_push_data;
    logic             q_push;
    logic             q_pop;

    logic             req_fire;
    logic             resp_fire;
    logic             resp_keep;
    logic             head_shown;
    logic [31:0]      target_pc;
    logic             target_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
    logic             adef_q;

    assign target_pc         = redirect_pc;
    assign target_misaligned = (redirect_pc[1:0] != 2'b00);
    assign fetch_adef        = adef_q && !cpu_rst;
`else
    assign target_pc         = redirect_pc & PC_ALIGN_MASK;
    assign target_misaligned = 1'b0;
`endif

    // Every in-flight request holds a queue slot, so a response can always
    // be enqueued. The !q_full term is redundant with the credit count and
    // only guards against a future change to that arithmetic.
    assign credits_used = {1'b0, outstanding} + {1'b0, q_count};
    assign imem_req     = !cpu_rst && (state == FETCH_ST_RUN) && !redirect_valid
                          && (credits_used < (CNT_W+1)'(FIFO_DEPTH)) && !q_full;
    assign imem_addr    = fetch_pc;
    assign req_fire     = imem_req && imem_gnt;

    // A response with nothing outstanding is stale (e.g. from before a reset)
    // and is ignored. A response in a redirect cycle belongs to the old path.
    assign resp_fire              = !cpu_rst && imem_rvalid && (outstanding != '0);
    assign resp_keep              = resp_fire && (discard == '0) && !redirect_valid;
    assign outstanding_after_resp = outstanding - CNT_W'(resp_fire);

    assign q_push      = resp_keep;
    assign q_push_data = '{pc: resp_pc, inst: imem_rdata};
    assign q_pop       = inst_valid && inst_ready;

    // Head data reads as zero whenever nothing is presented, so decode never
    // sees leftover storage contents after reset.
    assign head_shown = !cpu_rst && !q_empty;
    assign inst_valid = head_shown && !redirect_valid && (state != FETCH_ST_HALT);
    assign inst_out   = head_shown ? q_head.inst : 32'h0;
    assign inst_pc    = head_shown ? q_head.pc   : 32'h0;
    assign inst_pc4   = inst_pc + PC_STEP;

    fetch_queue #(
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk       (cpu_clk),
        .rst       (cpu_rst),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    // Front-end control. A redirect overrides everything: both PCs jump to
    // the target and every request still in flight (less one answered this
    // very cycle) is marked for discard. FLUSH idles until those responses
    // have drained so the new path never mixes with the old one.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state       <= FETCH_ST_BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            adef_q      <= 1'b0;
`endif
        end else if (redirect_valid) begin
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            outstanding <= outstanding_after_resp;
            discard     <= outstanding_after_resp;
            if (target_misaligned) begin
                state <= FETCH_ST_HALT;
            end else if (outstanding_after_resp != '0) begin
                state <= FETCH_ST_FLUSH;
            end else begin
                state <= FETCH_ST_RUN;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            adef_q      <= target_misaligned;
`endif
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (resp_keep) begin
                resp_pc <= resp_pc + PC_STEP;
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp_fire);
            if (resp_fire && (discard != '0)) begin
                discard <= discard - CNT_W'(1);
            end
            case (state)
                FETCH_ST_BOOT:  state <= FETCH_ST_RUN;
                FETCH_ST_FLUSH: if (discard == '0) state <= FETCH_ST_RUN;
                default:        state <= state;
            endcase
        end
    end

endmodule
